// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   state_e : FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   N_REQ   : number of requesters sharing the port
//   SEL_W   : width of the encoded grant / mux select
package arb_defs;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker over four requesters.
//   req   in  4  request vector
//   ptr   in  2  highest-priority index for this round
//   valid out 1  any request present
//   idx   out 2  first set request scanning ptr, ptr+1, ... mod 4
module rr_pick4
  import arb_defs::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Doubling the vector turns the circular scan into a plain slice:
  // rot[0] is requester ptr, rot[1] is ptr+1, and so on.
  always_comb begin
    dbl   = {req, req};
    rot   = dbl[ptr +: N_REQ];
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[SEL_W-1:0];
    end
    valid = |req;
    idx   = ptr + off;  // 2-bit add wraps back into range
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE -> IDLE; a watchdog
// aborts transactions the memory fails to acknowledge in time.
//   iClk    in   clock
//   iRst_n  in   async active-low reset
//   iReq    in 4 level requests, held until oDone
//   oGnt    out4 one-hot grant
//   oS1/oS0 out  encoded grant index (request-path mux select)
//   oMemReq out  request to the memory port (ISSUE and WAIT)
//   iMemAck in   memory completion, only looked at while oMemReq=1
//   oDone   out4 one-cycle completion pulse to the granted requester
//   oErr    out  with oDone when the transaction timed out
//   oBusy   out  arbiter not idle
module mem_port_arbiter
  import arb_defs::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [N_REQ-1:0] iReq,
  output logic [N_REQ-1:0] oGnt,
  output logic             oS1,
  output logic             oS0,
  output logic             oMemReq,
  input  logic             iMemAck,
  output logic [N_REQ-1:0] oDone,
  output logic             oErr,
  output logic             oBusy
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             to_q, to_d;

  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;

  rr_pick4 u_pick (
    .req   (iReq),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    to_d    = to_q;
    unique case (state_q)
      ST_IDLE: begin
        // Select only moves on a new grant so the mux never glitches.
        if (pick_vld) begin
          state_d = ST_ISSUE;
          sel_d   = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
          wd_d    = '0;
          to_d    = 1'b0;
        end
      end
      ST_ISSUE: begin
        // ISSUE counts as the first oMemReq cycle, so the count starts here.
        wd_d    = wd_q + TO_W'(1);
        state_d = iMemAck ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // Ack beats a coincident timeout.
        if (iMemAck) begin
          state_d = ST_DONE;
        end else if (wd_q >= TO_W'(TIMEOUT)) begin
          state_d = ST_DONE;
          to_d    = 1'b1;
        end else begin
          wd_d    = wd_q + TO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = sel_q + SEL_W'(1);  // just-served requester drops to last
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  // Outputs decode registered state only.
  assign oGnt    = gnt_q;
  assign oS1     = sel_q[1];
  assign oS0     = sel_q[0];
  assign oMemReq = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign oDone   = (state_q == ST_DONE) ? gnt_q : '0;
  assign oErr    = (state_q == ST_DONE) && to_q;
  assign oBusy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT=4). A transaction-level
// model predicts the grant from a round-robin pointer and the completion
// cycle from the ack position and the timeout limit.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [3:0] iReq = '0;
  logic       iMemAck = 1'b0;
  logic [3:0] oGnt, oDone;
  logic       oS1, oS0, oMemReq, oErr, oBusy;

  int n_cmp = 0;
  int n_err = 0;
  int ptr   = 0;   // model: requester with top priority next round
  int grants[$];   // model log of granted indices

  mem_port_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iReq    (iReq),
    .oGnt    (oGnt),
    .oS1     (oS1),
    .oS0     (oS0),
    .oMemReq (oMemReq),
    .iMemAck (iMemAck),
    .oDone   (oDone),
    .oErr    (oErr),
    .oBusy   (oBusy)
  );

  always #5 iClk = ~iClk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int p);
    for (int j = 0; j < 4; j++)
      if (req[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  // Called at a negedge with the DUT idle. k = oMemReq cycle (1-based) on
  // which ack is raised; beyond TO+1 the watchdog fires first.
  task automatic run_txn(input logic [3:0] req, input int k);
    int  g;
    bit  fin;
    g = pick(req, ptr);
    grants.push_back(g);
    iReq    = req;
    iMemAck = 1'($urandom_range(0, 1));   // ignored while idle
    @(posedge iClk); @(negedge iClk);
    chk("gnt", 32'(oGnt), 32'(1 << g));
    chk("sel", 32'({oS1, oS0}), 32'(g));
    chk("memreq_on", 32'(oMemReq), 32'd1);
    chk("busy", 32'(oBusy), 32'd1);
    fin = 0;
    for (int i = 1; !fin; i++) begin
      iMemAck = (i == k);
      iReq    = 4'($urandom) | 4'(1 << g);  // other bits may wander
      @(posedge iClk); @(negedge iClk);
      if (i == k || i == TO + 1) begin
        fin = 1;
        chk("done", 32'(oDone), 32'(1 << g));
        chk("err", 32'(oErr), 32'(i != k));
        chk("memreq_off", 32'(oMemReq), 32'd0);
      end else begin
        chk("memreq_hold", 32'(oMemReq), 32'd1);
        chk("no_done", 32'(oDone), 32'd0);
      end
    end
    ptr     = (g + 1) % 4;
    iMemAck = 1'($urandom_range(0, 1));
    iReq    = 4'($urandom);                // not sampled in DONE
    @(posedge iClk); @(negedge iClk);
    chk("idle_gnt", 32'(oGnt), 32'd0);
    chk("idle_busy", 32'(oBusy), 32'd0);
    chk("idle_done", 32'(oDone), 32'd0);
    chk("sel_hold", 32'({oS1, oS0}), 32'(g));
    iReq    = '0;
    iMemAck = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_gnt", 32'(oGnt), 32'd0);
    chk("rst_sel", 32'({oS1, oS0}), 32'd0);
    chk("rst_out", 32'({oMemReq, oDone, oErr, oBusy}), 32'd0);
    @(negedge iClk); iRst_n = 1'b1;
    @(negedge iClk);

    // idle with no request stays idle
    iReq = '0; iMemAck = 1'b1;
    @(posedge iClk); @(negedge iClk);
    chk("noreq_busy", 32'(oBusy), 32'd0);
    chk("noreq_memreq", 32'(oMemReq), 32'd0);
    iMemAck = 1'b0;

    // single request, ack on third oMemReq cycle
    run_txn(4'b0100, 3);

    // all four held, immediate ack: order from ptr=3 is 3,0,1,2,3
    grants.delete();
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 1);
    chk("order0", 32'(grants[0]), 32'd3);
    chk("order1", 32'(grants[1]), 32'd0);
    chk("order4", 32'(grants[4]), 32'd3);

    // pointer wrap: serve 3, then 1001 -> 0 then 3
    grants.delete();
    run_txn(4'b1000, 2);
    run_txn(4'b1001, 1);
    run_txn(4'b1001, 1);
    chk("wrap_a", 32'(grants[1]), 32'd0);
    chk("wrap_b", 32'(grants[2]), 32'd3);

    // timeout: never ack
    run_txn(4'b0010, 0);
    // ack on the timeout cycle wins
    run_txn(4'b0010, TO + 1);
    // one cycle past: times out
    run_txn(4'b0001, TO + 2);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, TO + 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge iClk); @(negedge iClk);
        chk("gap_busy", 32'(oBusy), 32'd0);
      end
    end

    // reset mid-WAIT: make ptr nonzero first
    run_txn(4'b0010, 1);               // ptr -> 2
    iReq = 4'b0100;
    @(posedge iClk); @(negedge iClk);  // ISSUE
    @(posedge iClk); @(negedge iClk);  // WAIT
    @(posedge iClk); @(negedge iClk);  // WAIT
    chk("pre_rst_memreq", 32'(oMemReq), 32'd1);
    #2 iRst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(oGnt), 32'd0);
    chk("arst_sel", 32'({oS1, oS0}), 32'd0);
    chk("arst_out", 32'({oMemReq, oDone, oErr, oBusy}), 32'd0);
    ptr = 0;
    @(negedge iClk);
    chk("rst_no_done", 32'(oDone), 32'd0);
    iRst_n = 1'b1; iReq = '0;
    @(negedge iClk);
    grants.delete();
    run_txn(4'b1111, 2);
    chk("post_rst_first", 32'(grants[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
